// File: rtl/mem_initiator_if.sv
// CPU-side request/response and memory-side strobe/data signals of the load/store initiator.
// slave is the initiator's view; master is the view of whatever drives the CPU and memory side.
interface mem_initiator_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  // Handshake: req is sampled only while the initiator is idle; ack (and err, when
  // present) pulse for exactly one cycle, and a new req is taken no earlier than the
  // cycle after ack. mem_read/mem_write are level strobes, never high together.
  modport slave (
    input  req, we, size, uns, addr, wdata, mem_rdata,
    output rdata, ack, err, busy, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req, we, size, uns, addr, wdata, mem_rdata,
    input  rdata, ack, err, busy, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_initiator.sv
// Byte/half/word load-store initiator for a big-endian word memory; sub-word stores
// are read-modify-write, misaligned accesses end in a one-cycle error.
module mem_initiator #(
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_initiator_if.slave bus,
  output logic [2:0]     o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(RD_LAT - 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_we, r_uns;
  logic [1:0]  r_size, r_off;
  logic [15:0] r_wdata;
  logic        r_ack, r_err, r_busy, r_mem_read, r_mem_write;
  logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;

  logic        w_accept, w_misal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_merge;

  assign w_accept = (r_state == S_IDLE) && bus.req;
  assign w_misal  = (bus.size == 2'b11) ||
                    (bus.size == 2'b01 && bus.addr[0]) ||
                    (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);

  // Lane select / merge on the memory word; offset 0 is the most significant byte.
  always_comb begin
    w_byte  = bus.mem_rdata[31:24];
    w_half  = r_off[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
    w_load  = bus.mem_rdata;
    w_merge = bus.mem_rdata;
    case (r_off)
      2'd1:    w_byte = bus.mem_rdata[23:16];
      2'd2:    w_byte = bus.mem_rdata[15:8];
      2'd3:    w_byte = bus.mem_rdata[7:0];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    case (r_size)
      2'b00: begin
        w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        case (r_off)
          2'd1:    w_merge[23:16] = r_wdata[7:0];
          2'd2:    w_merge[15:8]  = r_wdata[7:0];
          2'd3:    w_merge[7:0]   = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        if (r_off[1]) w_merge[15:0]  = r_wdata;
        else          w_merge[31:16] = r_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (w_misal) begin
            w_state_nxt = S_ERR;
          end else if (bus.we && bus.size == 2'b10) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
            w_cnt_nxt   = LP_CNT_LOAD;
          end
        end
      end
      S_RD: begin
        if (r_cnt == 4'd0) w_state_nxt = S_CAP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_CAP:   w_state_nxt = r_we ? S_WR : S_DONE;
      S_WR:    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes and pulses are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_wdata     <= 16'd0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_ack       <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ERR);
      r_err       <= (w_state_nxt == S_ERR);
      r_mem_read  <= (w_state_nxt == S_RD);
      r_mem_write <= (w_state_nxt == S_WR);
      if (w_accept) begin
        r_we       <= bus.we;
        r_size     <= bus.size;
        r_uns      <= bus.uns;
        r_off      <= bus.addr[1:0];
        r_wdata    <= bus.wdata[15:0];
        r_mem_addr <= {bus.addr[31:2], 2'b00};
        if (bus.we) r_mem_wdata <= bus.wdata;
      end
      if (r_state == S_CAP) begin
        if (r_we) r_mem_wdata <= w_merge;
        else      r_rdata     <= w_load;
      end
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.ack       = r_ack;
  assign bus.err       = r_err;
  assign bus.busy      = r_busy;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter RD_LAT, default 1, is the number of cycles mem_read is held before mem_rdata is sampled (range 1..15).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  CPU access request; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 size  input  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-007 uns  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-008 addr  input  32  CPU byte address.
REQ-009 wdata  input  32  store data, right-justified for sub-word stores.
REQ-010 rdata  output  32  load result, right-justified and extended.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle error pulse, coincident with ack.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mem_addr  output  32  word-aligned address to the memory: {addr[31:2],2'b00}.
REQ-015 mem_wdata  output  32  full word to the memory.
REQ-016 mem_read  output  1  memory read strobe.
REQ-017 mem_write  output  1  memory write strobe.
REQ-018 mem_rdata  input  32  memory read data, big-endian (byte at offset 0 = bits 31:24).

Function
REQ-019 States: IDLE, RD, CAP, WR, DONE, ERR; all state and outputs are registered.
REQ-020 In IDLE with req=1, the block latches we/size/uns/addr/wdata at the clock edge; req in any other state is ignored.
REQ-021 Misaligned accesses go IDLE->ERR and drive no memory strobe: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
REQ-022 Word load: IDLE->RD->CAP->DONE->IDLE.
REQ-023 Word store: IDLE->WR->DONE->IDLE.
REQ-024 Byte and half stores are read-modify-write: IDLE->RD->CAP->WR->DONE->IDLE.
REQ-025 In RD, mem_read=1 for exactly RD_LAT cycles, counted by a 4-bit down-counter loaded with RD_LAT-1; the state leaves RD when the counter reaches 0.
REQ-026 In CAP, the block registers mem_rdata once; mem_read=0 in CAP.
REQ-027 In WR, mem_write=1 for exactly one cycle with mem_wdata stable; mem_read=0.
REQ-028 Byte lane mapping for offset o=addr[1:0] is big-endian: byte lane bits [31-8o : 24-8o]; half lane is bits 31:16 for o=0 and bits 15:0 for o=2.
REQ-029 On a load, CAP extracts the lane and extends it to 32 bits according to uns; rdata is updated in CAP and held until the next load completes.
REQ-030 On an RMW, CAP replaces only the addressed lane of the read word with wdata[7:0] or wdata[15:0]; the other bytes are preserved bit-exact.
REQ-031 For a word store, mem_wdata = wdata.
REQ-032 ack=1 for one cycle in DONE (err=0) or in ERR (err=1); the next state is always IDLE.
REQ-033 A new request is therefore accepted no earlier than the cycle after ack.
REQ-034 mem_addr is held constant from RD through WR of one transaction.
REQ-035 mem_read and mem_write are never high in the same cycle.
REQ-036 Latency from the accept edge to ack: word store 2 cycles; word or sub-word load RD_LAT+2 cycles; sub-word store RD_LAT+3 cycles; error 1 cycle.

Reset
REQ-037 rst_n=0 forces, asynchronously, state=IDLE, counter=0, and ack, err, busy, mem_read, mem_write=0.
REQ-038 rst_n=0 also forces rdata, mem_addr and mem_wdata to 0.
REQ-039 Reset asserted mid-transaction aborts it: no ack is issued and a pending mem_write is dropped immediately.
REQ-040 After rst_n rises, the first rising edge samples req normally.

Verification
REQ-041 Memory model: word 0x100 = 0x11223344, RD_LAT=1; load byte addr=0x102, uns=0 -> one mem_read cycle at mem_addr=0x100, rdata=0x00000033, ack 3 cycles after accept.
REQ-042 Memory word 0x100 = 0x11228344; load half addr=0x102, uns=0 -> rdata=0xFFFF8344; repeat with uns=1 -> rdata=0x00008344.
REQ-043 Store byte addr=0x101, wdata=0xAB, word 0x100 = 0x11223344 -> RD then WR, mem_wdata=0x11AB3344, ack 4 cycles after accept.
REQ-044 Store word addr=0x102 -> err=1 and ack=1 one cycle after accept, no mem_read or mem_write; store half addr=0x103 behaves the same.
REQ-045 RD_LAT=3; word load -> mem_read high exactly 3 cycles, ack 5 cycles after accept; req held high throughout -> exactly one transaction until after ack.
REQ-046 Drop rst_n during WR of an RMW -> mem_write falls with no clock edge, no ack; after release, a word store to 0x200 completes normally.
